// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// fpu_seq_pkg : shared types and op-latency lookup for the FPU sequencer
// Rev 1.0
// ============================================================================
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    FADD = 2'b00,
    FSUB = 2'b01,
    FMUL = 2'b10,
    FDIV = 2'b11
  } fpu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } fpu_state_t;

  function automatic int unsigned op_latency(input fpu_op_t op,
                                             input int unsigned add_lat,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    int unsigned lat;
    case (op)
      FADD, FSUB: lat = add_lat;
      FMUL:       lat = mul_lat;
      default:    lat = div_lat;
    endcase
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_lat_counter.sv
`default_nettype none
// ============================================================================
// fpu_lat_counter : loadable down-counter, saturating at zero, with a flag
//                   raised while the count sits at one (final busy cycle)
// Rev 1.0
// ============================================================================
module fpu_lat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// fpu_sequencer : issues one multi-cycle FP op at a time, stalls the core for
//                 its latency, then pulses the FP register-file write-back.
// Build option  : FPU_DIV_EN enables the divide op (otherwise op 11 is illegal)
// Rev 1.0
// ============================================================================
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fp_issue,
  input  logic [3:0] fpu_control,
  input  logic [4:0] fd,
  output logic       stall,
  output logic       fpu_go,
  output logic [1:0] fpu_op,
  output logic       fp_wb_en,
  output logic [4:0] fp_wb_addr,
  output logic       illegal_op,
  output logic       busy
);

  localparam int unsigned MAX_AM = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
`ifdef FPU_DIV_EN
  localparam int unsigned MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
`else
  localparam int unsigned MAX_LAT = MAX_AM;
`endif
  localparam int unsigned CNT_W = $clog2(MAX_LAT) + 1;

  fpu_state_t  state;
  fpu_state_t  state_nxt;
  fpu_op_t     op_in;
  fpu_op_t     op_q;
  logic [4:0]  fd_q;
  logic        legal;
  logic        issue_ok;
  logic        go;
  logic        cnt_last;
  int unsigned lat;
  logic [CNT_W-1:0] lat_m1;

  assign op_in = fpu_op_t'(fpu_control[1:0]);

`ifdef FPU_DIV_EN
  assign legal = (fpu_control[3:2] == 2'b00);
`else
  assign legal = (fpu_control[3:2] == 2'b00) && (op_in != FDIV);
`endif

  // Issue logic is gated by reset so nothing fires while reset is held.
  assign issue_ok = reset && (state == IDLE) && fp_issue;
  assign go       = issue_ok && legal;

  assign lat    = op_latency(op_in, ADD_LAT, MUL_LAT, DIV_LAT);
  assign lat_m1 = CNT_W'(lat - 1);

  fpu_lat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (go),
    .load_val (lat_m1),
    .dec      (state == BUSY),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= FADD;
      fd_q <= '0;
    end else if (go) begin
      op_q <= op_in;
      fd_q <= fd;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = (lat > 1) ? BUSY : WB;
        end
      end
      BUSY: begin
        if (cnt_last) begin
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fpu_go     = go;
    illegal_op = issue_ok && !legal;
    stall      = go || (state == BUSY);
    busy       = (state != IDLE);
    fp_wb_en   = (state == WB);
    fp_wb_addr = (state == WB) ? fd_q : 5'd0;
    fpu_op     = 2'b00;
    if (go) begin
      fpu_op = fpu_control[1:0];
    end else if (state != IDLE) begin
      fpu_op = op_q;
    end
  end

endmodule
`default_nettype wire
